vga_timing_decoder: RTL and testbench

- Receive-side counterpart of `vga_controller`: consumes a VGA-style stream (active-low HS/VS, active-low blank, 8-bit RGB) and recovers pixel coordinates.
- Measures line and frame timing, locks to the nominal mode and flags timing violations.
- Produces a per-frame RGB checksum.
- Sits on the pixel clock domain beside `vga_controller`, tapping its outputs for self-check, or on an external video source.

---
 rtl/vga_timing_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from sync/blank,
// measures line and frame timing, locks to the nominal mode and checksums each frame.
module vga_timing_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        hsync_n_i,
  input  logic        vsync_n_i,
  input  logic        blank_n_i,
  input  logic [7:0]  red_i,
  input  logic [7:0]  green_i,
  input  logic [7:0]  blue_i,
  output logic [9:0]  x_pixel_coord_o,
  output logic [9:0]  y_pixel_coord_o,
  output logic        pixel_valid_o,
  output logic [11:0] line_period_o,
  output logic [10:0] frame_lines_o,
  output logic [15:0] frame_checksum_o,
  output logic        frame_done_o,
  output logic        locked_o,
  output logic        timing_error_o
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  logic        hs_p0, vs_p0, vld_p0;
  logic        hs_p1, vs_p1, vld_p1;
  logic [7:0]  r_p0, g_p0, b_p0;

  logic [11:0] h_cnt;
  logic [10:0] line_cnt, px_cnt, y_cnt;
  logic [15:0] acc;

  state_t      state_q, state_d;
  logic [3:0]  good;
  logic        armed, h_valid, bad_q, err_q, done_q;

  logic        hs_edge, vs_edge, act_rise, act_fall;
  logic [11:0] h_period;
  logic [10:0] act_lines;
  logic [15:0] px_sum, acc_next;
  logic [4:0]  good_inc;
  logic        line_bad, px_bad, frm_bad, any_bad, frame_ok, measure_entry;

  // Stage p0: input register; p1 holds the previous p0 sample for edge detection
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      vld_p0 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      hs_p0  <= hsync_n_i;
      vs_p0  <= vsync_n_i;
      vld_p0 <= blank_n_i;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clock_i) begin
    r_p0 <= red_i;
    g_p0 <= green_i;
    b_p0 <= blue_i;
  end

  always_comb begin
    hs_edge       = hs_p1 & ~hs_p0;
    vs_edge       = vs_p1 & ~vs_p0;
    act_rise      = ~vld_p1 & vld_p0;
    act_fall      = vld_p1 & ~vld_p0;
    h_period      = sat_inc12(h_cnt);
    act_lines     = act_fall ? sat_inc11(y_cnt) : y_cnt;
    px_sum        = 16'(r_p0) + 16'(g_p0) + 16'(b_p0);
    acc_next      = acc + (vld_p0 ? px_sum : 16'd0);
    good_inc      = {1'b0, good} + 5'd1;
    // The first line closed after entering MEASURE started before measurement did
    line_bad      = hs_edge & h_valid & (h_period != 12'(H_TOTAL));
    px_bad        = act_fall & (px_cnt != 11'(H_ACTIVE));
    frm_bad       = vs_edge & ((line_cnt != 11'(V_TOTAL)) | (act_lines != 11'(V_ACTIVE)));
    any_bad       = line_bad | px_bad | frm_bad;
    frame_ok      = ~(bad_q | any_bad);
    measure_entry = (state_d == MEASURE) && (state_q != MEASURE);
  end

  // Stage p1 -> outputs: measurement counters and registered results
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      h_cnt            <= '0;
      line_cnt         <= '0;
      px_cnt           <= '0;
      y_cnt            <= '0;
      acc              <= '0;
      line_period_o    <= '0;
      frame_lines_o    <= '0;
      frame_checksum_o <= '0;
      pixel_valid_o    <= 1'b0;
      x_pixel_coord_o  <= '0;
      y_pixel_coord_o  <= '0;
    end else begin
      if (hs_edge) begin
        h_cnt         <= '0;
        line_period_o <= h_period;
      end else begin
        h_cnt <= sat_inc12(h_cnt);
      end

      // A coincident hsync is counted as the first line of the new frame
      if (vs_edge) begin
        frame_lines_o <= line_cnt;
        line_cnt      <= hs_edge ? 11'd1 : 11'd0;
      end else if (hs_edge) begin
        line_cnt <= sat_inc11(line_cnt);
      end

      if (act_rise)    px_cnt <= 11'd1;
      else if (vld_p0) px_cnt <= sat_inc11(px_cnt);

      if (vs_edge)       y_cnt <= '0;
      else if (act_fall) y_cnt <= sat_inc11(y_cnt);

      if (vs_edge) begin
        frame_checksum_o <= acc_next;
        acc              <= '0;
      end else begin
        acc <= acc_next;
      end

      pixel_valid_o <= vld_p0;
      if (vld_p0) begin
        x_pixel_coord_o <= act_rise ? 10'd0 : px_cnt[9:0];
        y_pixel_coord_o <= vs_edge ? 10'd0 : y_cnt[9:0];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_edge) state_d = MEASURE;
      MEASURE: if (vs_edge && frame_ok && (good_inc == 5'(LOCK_FRAMES))) state_d = LOCKED;
      LOCKED:  if (any_bad) state_d = MEASURE;
      default: state_d = SEARCH;
    endcase
  end

  // Lock bookkeeping; armed suppresses frame_done on the first vsync after reset or loss of lock
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      good    <= '0;
      armed   <= 1'b0;
      h_valid <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SEARCH:  if (vs_edge) good <= '0;
        MEASURE: if (vs_edge) good <= frame_ok ? good_inc[3:0] : 4'd0;
        LOCKED:  if (any_bad) good <= '0;
        default: good <= '0;
      endcase

      if ((state_q == LOCKED) && any_bad) armed <= 1'b0;
      else if (vs_edge)                   armed <= 1'b1;

      if (measure_entry) h_valid <= 1'b0;
      else if (hs_edge)  h_valid <= 1'b1;

      if (vs_edge)                bad_q <= 1'b0;
      else if (line_bad | px_bad) bad_q <= 1'b1;

      err_q  <= (state_q == LOCKED) && any_bad;
      done_q <= vs_edge && armed;
    end
  end

  always_comb begin
    locked_o       = (state_q == LOCKED);
    timing_error_o = err_q;
    frame_done_o   = done_q;
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced 50x36 mode (40x30 active)
// so that many complete frames fit in a short run.
module tb_vga_timing_decoder;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        hsync_n, vsync_n, blank_n;
  logic [7:0]  red, green, blue;
  logic [9:0]  x_pixel_coord_o, y_pixel_coord_o;
  logic        pixel_valid_o;
  logic [11:0] line_period_o;
  logic [10:0] frame_lines_o;
  logic [15:0] frame_checksum_o;
  logic        frame_done_o, locked_o, timing_error_o;

  vga_timing_decoder #(
    .H_TOTAL(50), .V_TOTAL(36), .H_ACTIVE(40), .V_ACTIVE(30), .LOCK_FRAMES(2)
  ) dut (
    .clock_i(clk), .reset_i(reset_i),
    .hsync_n_i(hsync_n), .vsync_n_i(vsync_n), .blank_n_i(blank_n),
    .red_i(red), .green_i(green), .blue_i(blue),
    .x_pixel_coord_o(x_pixel_coord_o), .y_pixel_coord_o(y_pixel_coord_o),
    .pixel_valid_o(pixel_valid_o), .line_period_o(line_period_o),
    .frame_lines_o(frame_lines_o), .frame_checksum_o(frame_checksum_o),
    .frame_done_o(frame_done_o), .locked_o(locked_o), .timing_error_o(timing_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    int   stretch_ln, short_ln, skip_ln;
    int   exp_done, exp_err;
    logic exp_lock;
    int   exp_lines, exp_cks, exp_period;
  } vec_t;

  vec_t tbl [12];
  int   nvec = 0, nmis = 0;
  int   done_cnt, err_cnt;
  bit   coord_chk;
  logic h1_bl, h2_bl;
  int   h1_x, h1_y, h2_x, h2_y, ex_x, ex_y;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_hist();
    h1_bl = 1'b0; h2_bl = 1'b0;
    h1_x = 0; h1_y = 0; h2_x = 0; h2_y = 0;
    ex_x = 0; ex_y = 0;
  endtask

  // One pixel clock: sample outputs (they reflect the pins driven two steps ago), then drive
  task automatic step(input logic hs, input logic vs, input logic bl,
                      input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input int hx, input int hy);
    @(negedge clk);
    if (frame_done_o)   done_cnt++;
    if (timing_error_o) err_cnt++;
    if (coord_chk) begin
      if (h2_bl) begin ex_x = h2_x; ex_y = h2_y; end
      chk("coord{valid,x,y}", {11'd0, pixel_valid_o, x_pixel_coord_o, y_pixel_coord_o},
          {11'd0, h2_bl, ex_x[9:0], ex_y[9:0]});
    end
    h2_bl = h1_bl; h2_x = h1_x; h2_y = h1_y;
    h1_bl = bl;    h1_x = hx;   h1_y = hy;
    hsync_n = hs; vsync_n = vs; blank_n = bl;
    red = rr; green = gg; blue = bb;
  endtask

  task automatic drive_line(input int ln, input int len, input int act,
                            input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    for (int h = 0; h < len; h++)
      step(!(h >= 42 && h < 46), !(ln == 32 || ln == 33), (ln < 30) && (h < act),
           rr, gg, bb, h, ln);
  endtask

  task automatic frame(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                       input int stretch_ln, input int short_ln, input int skip_ln);
    for (int ln = 0; ln < 36; ln++)
      if (ln != skip_ln)
        drive_line(ln, (ln == stretch_ln) ? 51 : 50, (ln == short_ln) ? 39 : 40, rr, gg, bb);
  endtask

  task automatic hsp(input int n);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0);
    for (int i = 1; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"},      32'(x_pixel_coord_o), 32'd0);
    chk({tag, "_y"},      32'(y_pixel_coord_o), 32'd0);
    chk({tag, "_valid"},  32'(pixel_valid_o), 32'd0);
    chk({tag, "_period"}, 32'(line_period_o), 32'd0);
    chk({tag, "_lines"},  32'(frame_lines_o), 32'd0);
    chk({tag, "_cks"},    32'(frame_checksum_o), 32'd0);
    chk({tag, "_done"},   32'(frame_done_o), 32'd0);
    chk({tag, "_locked"}, 32'(locked_o), 32'd0);
    chk({tag, "_err"},    32'(timing_error_o), 32'd0);
  endtask

  initial begin
    // r g b, stretch/short/skip line, done pulses, error pulses, locked, lines, checksum, period
    tbl[0]  = '{8'd1,   8'd2,   8'd3,   -1, -1, -1, 0, 0, 1'b0, 32, 7200,  50};
    tbl[1]  = '{8'd255, 8'd255, 8'd255, -1, -1, -1, 1, 0, 1'b0, 36, 496,   50};
    tbl[2]  = '{8'd10,  8'd20,  8'd30,  -1, -1, -1, 1, 0, 1'b1, 36, 6464,  50};
    tbl[3]  = '{8'd1,   8'd2,   8'd3,    5, -1, -1, 0, 1, 1'b0, 36, 7200,  50};
    tbl[4]  = '{8'd0,   8'd0,   8'd0,   -1, -1, -1, 1, 0, 1'b0, 36, 0,     50};
    tbl[5]  = '{8'd100, 8'd0,   8'd0,   -1, -1, -1, 1, 0, 1'b1, 36, 54464, 50};
    tbl[6]  = '{8'd1,   8'd2,   8'd3,   -1,  7, -1, 0, 1, 1'b0, 36, 7194,  50};
    tbl[7]  = '{8'd1,   8'd2,   8'd3,   -1, -1, -1, 1, 0, 1'b0, 36, 7200,  50};
    tbl[8]  = '{8'd1,   8'd2,   8'd3,   -1, -1, -1, 1, 0, 1'b1, 36, 7200,  50};
    tbl[9]  = '{8'd1,   8'd2,   8'd3,   -1, -1, 31, 1, 1, 1'b0, 35, 7200,  50};
    tbl[10] = '{8'd1,   8'd2,   8'd3,   -1, -1, -1, 0, 0, 1'b0, 36, 7200,  50};
    tbl[11] = '{8'd1,   8'd2,   8'd3,   -1, -1, -1, 1, 0, 1'b1, 36, 7200,  50};

    reset_i = 1'b1;
    hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    coord_chk = 1'b0;
    done_cnt = 0; err_cnt = 0;
    clear_hist();
    repeat (3) @(negedge clk);
    check_zero("por");
    @(negedge clk);
    reset_i = 1'b0;
    clear_hist();
    coord_chk = 1'b1;

    for (int i = 0; i < 12; i++) begin
      done_cnt = 0; err_cnt = 0;
      frame(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].stretch_ln, tbl[i].short_ln, tbl[i].skip_ln);
      chk($sformatf("f%0d_done", i),   32'(done_cnt), 32'(tbl[i].exp_done));
      chk($sformatf("f%0d_err", i),    32'(err_cnt), 32'(tbl[i].exp_err));
      chk($sformatf("f%0d_locked", i), 32'(locked_o), 32'(tbl[i].exp_lock));
      chk($sformatf("f%0d_lines", i),  32'(frame_lines_o), 32'(tbl[i].exp_lines));
      chk($sformatf("f%0d_cks", i),    32'(frame_checksum_o), 32'(tbl[i].exp_cks));
      chk($sformatf("f%0d_period", i), 32'(line_period_o), 32'(tbl[i].exp_period));
    end

    // Reset in the middle of an active line while locked
    for (int ln = 0; ln < 3; ln++) drive_line(ln, 50, 40, 8'd1, 8'd2, 8'd3);
    drive_line(3, 21, 40, 8'd1, 8'd2, 8'd3);
    chk("pre_reset_locked", 32'(locked_o), 32'd1);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check_zero("midreset");
    hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    clear_hist();

    for (int f = 0; f < 3; f++) begin
      done_cnt = 0; err_cnt = 0;
      frame(8'd1, 8'd2, 8'd3, -1, -1, -1);
      chk($sformatf("relock%0d_done", f),   32'(done_cnt), (f == 0) ? 32'd0 : 32'd1);
      chk($sformatf("relock%0d_locked", f), 32'(locked_o), (f == 2) ? 32'd1 : 32'd0);
      chk($sformatf("relock%0d_err", f),    32'(err_cnt), 32'd0);
    end

    // Long hsync gap: period saturates at 4095 rather than wrapping
    @(negedge clk);
    reset_i = 1'b1;
    coord_chk = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    clear_hist();
    hsp(10);
    hsp(5000);
    hsp(30);
    chk("sat_period", 32'(line_period_o), 32'd4095);
    chk("sat_locked", 32'(locked_o), 32'd0);
    hsp(5);
    chk("short_period", 32'(line_period_o), 32'd30);
    chk("no_vs_lines", 32'(frame_lines_o), 32'd0);
    chk("no_vs_locked", 32'(locked_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
